// File: rtl/demux2_32_buffered.sv
// demux2_32_buffered: steers one producer stream to one of two consumers.
// Each consumer owns a one-entry holding register with a valid/ready
// handshake, so a stalled consumer never blocks or corrupts the other path.
// Drain and refill can happen on the same edge, which gives one word per
// cycle per output.
module demux2_32_buffered #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Src,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out1_valid_reg;
  logic [WIDTH-1:0] out1_data_reg;
  logic [CNT_W-1:0] cnt1_reg;
  logic             out2_valid_reg;
  logic [WIDTH-1:0] out2_data_reg;
  logic [CNT_W-1:0] cnt2_reg;

  logic slot1_free;
  logic slot2_free;
  logic accept1;
  logic accept2;

  // A slot can take a word when it is empty or being emptied this cycle.
  // in_ready looks only at the selected slot and never at in_valid.
  always_comb begin
    slot1_free = !out1_valid_reg || out1_ready;
    slot2_free = !out2_valid_reg || out2_ready;
    in_ready   = Src ? slot2_free : slot1_free;
    accept1    = in_valid && slot1_free && !Src;
    accept2    = in_valid && slot2_free && Src;
  end

  // Consumer 1 holding register: refill has priority over drain; data is
  // left untouched on drain so the last word stays visible.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out1_valid_reg <= 1'b0;
      out1_data_reg  <= '0;
      cnt1_reg       <= '0;
    end else if (accept1) begin
      out1_valid_reg <= 1'b1;
      out1_data_reg  <= in_data;
      cnt1_reg       <= cnt1_reg + CNT_ONE;
    end else if (out1_ready) begin
      out1_valid_reg <= 1'b0;
    end
  end

  // Consumer 2 holding register, same policy as consumer 1.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      out2_valid_reg <= 1'b0;
      out2_data_reg  <= '0;
      cnt2_reg       <= '0;
    end else if (accept2) begin
      out2_valid_reg <= 1'b1;
      out2_data_reg  <= in_data;
      cnt2_reg       <= cnt2_reg + CNT_ONE;
    end else if (out2_ready) begin
      out2_valid_reg <= 1'b0;
    end
  end

  assign out1_valid = out1_valid_reg;
  assign out1_data  = out1_data_reg;
  assign cnt1       = cnt1_reg;
  assign out2_valid = out2_valid_reg;
  assign out2_data  = out2_data_reg;
  assign cnt2       = cnt2_reg;

endmodule

// File: tb/tb_demux2_32_buffered.sv
// Self-checking bench for demux2_32_buffered: directed scenarios plus a
// randomized run compared against a behavioural model of the two slots.
module tb_demux2_32_buffered;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Src = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
  logic [31:0] out1_data;
  logic        out2_valid;
  logic        out2_ready = 1'b0;
  logic [31:0] out2_data;
  logic [7:0]  cnt1;
  logic [7:0]  cnt2;

  int checks = 0;
  int errors = 0;

  // behavioural model: one slot per consumer plus accept counters
  bit          mv1, mv2;
  logic [31:0] md1, md2;
  int          mc1, mc2;

  demux2_32_buffered #(.WIDTH(32), .CNT_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .Src(Src),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 CLK = ~CLK;

  task automatic model_clear();
    mv1 = 0; mv2 = 0; md1 = '0; md2 = '0; mc1 = 0; mc2 = 0;
  endtask

  // One rising edge worth of behaviour, from the handshake rules.
  task automatic model_edge();
    bit room, acc;
    room = Src ? (!mv2 || out2_ready) : (!mv1 || out1_ready);
    acc  = in_valid && room;
    if (acc && !Src) begin md1 = in_data; mv1 = 1; mc1 = (mc1 + 1) % 256; end
    else if (out1_ready) mv1 = 0;
    if (acc && Src) begin md2 = in_data; mv2 = 1; mc2 = (mc2 + 1) % 256; end
    else if (out2_ready) mv2 = 0;
  endtask

  // Advance one clock; inputs are driven after the falling edge.
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic async_reset_pulse();
    #2 Reset = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    Src = 0; in_valid = 0; out1_ready = 0; out2_ready = 0;
    async_reset_pulse();
    checks++;
    if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || out1_data !== 32'h0 ||
        out2_data !== 32'h0 || cnt1 !== 8'd0 || cnt2 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: v1=%b v2=%b d1=%h d2=%h c1=%0d c2=%0d expected all zero",
               out1_valid, out2_valid, out1_data, out2_data, cnt1, cnt2);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(negedge CLK);
    Reset = 1'b0;
    $display("reset: cnt1=%0d cnt2=%0d in_ready=%b", cnt1, cnt2, in_ready);
  endtask

  task automatic test_single_accept();
    Src = 0; in_data = 32'hDEADBEEF; in_valid = 1; out1_ready = 0; out2_ready = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready);
    end
    cycle();
    in_valid = 0;
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hDEADBEEF || cnt1 !== 8'd1 ||
        out2_valid !== 1'b0 || cnt2 !== 8'd0) begin
      errors++;
      $display("FAIL single_accept: v1=%b d1=%h c1=%0d v2=%b c2=%0d expected 1 deadbeef 1 0 0",
               out1_valid, out1_data, cnt1, out2_valid, cnt2);
    end
    $display("single: out1_data=%h cnt1=%0d", out1_data, cnt1);
  endtask

  task automatic test_src_switch();
    Src = 0; in_valid = 1; in_data = 32'h12345678; out1_ready = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
    end
    cycle();
    checks++;
    if (out1_data !== 32'hDEADBEEF || out1_valid !== 1'b1 || cnt1 !== 8'd1) begin
      errors++;
      $display("FAIL stall_hold: d1=%h v1=%b c1=%0d expected deadbeef 1 1", out1_data, out1_valid, cnt1);
    end
    Src = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL switch_in_ready: got %b expected 1", in_ready);
    end
    cycle();
    in_valid = 0;
    checks++;
    if (out2_valid !== 1'b1 || out2_data !== 32'h12345678 || cnt2 !== 8'd1 ||
        out1_valid !== 1'b1 || out1_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL switch_route: v2=%b d2=%h c2=%0d v1=%b d1=%h expected 1 12345678 1 1 deadbeef",
               out2_valid, out2_data, cnt2, out1_valid, out1_data);
    end
    $display("switch: out2_data=%h cnt2=%0d", out2_data, cnt2);
  endtask

  task automatic test_back_to_back();
    int base;
    base = 1;  // one word accepted to output 1 so far
    Src = 0; out1_ready = 1; out2_ready = 1; in_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      cycle();
      checks++;
      if (out1_valid !== 1'b1 || out1_data !== 32'(i) || cnt1 !== 8'(base + i)) begin
        errors++;
        $display("FAIL b2b_%0d: v1=%b d1=%h c1=%0d expected 1 %h %0d",
                 i, out1_valid, out1_data, cnt1, 32'(i), base + i);
      end
      $display("b2b: word %0d out1_data=%h cnt1=%0d", i, out1_data, cnt1);
    end
    in_valid = 0;
    cycle();
    checks++;
    if (out1_valid !== 1'b0 || out1_data !== 32'd8 || out2_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: v1=%b d1=%h v2=%b expected 0 00000008 0", out1_valid, out1_data, out2_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] w;
    Src = 1; out2_ready = 0; out1_ready = 0; in_valid = 1; in_data = $urandom;
    cycle();
    checks++;
    if (out2_valid !== 1'b1) begin
      errors++; $display("FAIL mid_fill: v2=%b expected 1", out2_valid);
    end
    async_reset_pulse();
    checks++;
    if (out2_valid !== 1'b0 || cnt2 !== 8'd0 || out2_data !== 32'h0 || cnt1 !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: v2=%b c2=%0d d2=%h c1=%0d rdy=%b expected 0 0 0 0 1",
               out2_valid, cnt2, out2_data, cnt1, in_ready);
    end
    @(negedge CLK);
    Reset = 1'b0;
    w = $urandom;
    in_data = w;
    cycle();
    in_valid = 0;
    checks++;
    if (cnt2 !== 8'd1 || out2_valid !== 1'b1 || out2_data !== w) begin
      errors++;
      $display("FAIL post_reset: c2=%0d v2=%b d2=%h expected 1 1 %h", cnt2, out2_valid, out2_data, w);
    end
    $display("midreset: cnt2=%0d out2_data=%h", cnt2, out2_data);
  endtask

  task automatic test_wrap();
    logic [31:0] last;
    Src = 0; in_valid = 0; out1_ready = 0; out2_ready = 0;
    async_reset_pulse();
    @(negedge CLK);
    Reset = 1'b0;
    last = '0;
    Src = 1; out2_ready = 1; in_valid = 1;
    for (int i = 1; i <= 256; i++) begin
      last = $urandom;
      in_data = last;
      out1_ready = 1'($urandom);
      cycle();
      if (i == 255) begin
        checks++;
        if (cnt2 !== 8'd255) begin
          errors++; $display("FAIL wrap_255: c2=%0d expected 255", cnt2);
        end
      end
    end
    in_valid = 0;
    checks++;
    if (cnt2 !== 8'd0 || cnt1 !== 8'd0 || out2_data !== last || out2_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_0: c2=%0d c1=%0d d2=%h v2=%b expected 0 0 %h 1", cnt2, cnt1, out2_data, out2_valid, last);
    end
    $display("wrap: cnt2=%0d cnt1=%0d", cnt2, cnt1);
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 400; i++) begin
      Src        = 1'($urandom);
      in_valid   = ($urandom_range(0, 9) < 7);
      in_data    = $urandom;
      out1_ready = 1'($urandom);
      out2_ready = 1'($urandom);
      #1;
      exp_rdy = Src ? (!mv2 || out2_ready) : (!mv1 || out1_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_rdy_%0d: got %b expected %b", i, in_ready, exp_rdy);
      end
      cycle();
      checks++;
      if (out1_valid !== mv1 || out2_valid !== mv2 || out1_data !== md1 || out2_data !== md2 ||
          cnt1 !== 8'(mc1) || cnt2 !== 8'(mc2)) begin
        errors++;
        $display("FAIL rand_state_%0d: v1=%b d1=%h c1=%0d v2=%b d2=%h c2=%0d expected %b %h %0d %b %h %0d",
                 i, out1_valid, out1_data, cnt1, out2_valid, out2_data, cnt2,
                 mv1, md1, mc1, mv2, md2, mc2);
      end
      $display("rand %0d: src=%b iv=%b r1=%b r2=%b c1=%0d c2=%0d",
               i, Src, in_valid, out1_ready, out2_ready, cnt1, cnt2);
    end
    in_valid = 0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_accept();
    test_src_switch();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
